// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - five-stage pipeline hazard and sequencing controller
module pipe_ctrl (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        mem_dreq,
  input  logic        ex_load,
  input  logic [4:0]  ex_wsel,
  input  logic [4:0]  dc_rsel1,
  input  logic [4:0]  dc_rsel2,
  input  logic        dc_uses_rt,
  input  logic        redirect,
  input  logic        wb_halt,
  output logic        pc_en,
  output logic        pipe1_en,
  output logic        pipe2_en,
  output logic        pipe3_en,
  output logic        pipe4_en,
  output logic        flushed1,
  output logic        flushed2,
  output logic        halt,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, REDIR_WAIT, HALTED} state_t;

  state_t      state_q, state_d;
  logic        halt_q, halt_d;
  logic [15:0] cnt_q, cnt_d;
  logic        lu, dstall;
  logic        pc_en_w, p1_w, p2_w, p3_w, p4_w, f1_w, f2_w;

  assign lu = ex_load && (ex_wsel != 5'd0) &&
              ((ex_wsel == dc_rsel1) || (dc_uses_rt && (ex_wsel == dc_rsel2)));
  assign dstall = mem_dreq && !dhit;

  // Priority decision: halt, memory freeze, redirect, stale-fetch squash, load-use, imem miss.
  always_comb begin
    state_d = state_q;
    pc_en_w = 1'b0;
    p1_w    = 1'b0;
    p2_w    = 1'b0;
    p3_w    = 1'b0;
    p4_w    = 1'b0;
    f1_w    = 1'b0;
    f2_w    = 1'b0;
    if (state_q != HALTED) begin
      if (wb_halt) begin
        state_d = HALTED;
      end else if (dstall) begin
        state_d = state_q;
      end else if (redirect) begin
        pc_en_w = 1'b1;
        {p1_w, p2_w, p3_w, p4_w} = 4'b1111;
        {f1_w, f2_w} = 2'b11;
        state_d = ihit ? RUN : REDIR_WAIT;
      end else if (state_q == REDIR_WAIT) begin
        // The word returning now belongs to the old path; bubble it into DC.
        {p1_w, p2_w, p3_w, p4_w} = 4'b1111;
        f1_w = 1'b1;
        if (ihit) state_d = RUN;
      end else if (lu) begin
        {p2_w, p3_w, p4_w} = 3'b111;
        f2_w = 1'b1;
      end else if (!ihit) begin
        {p1_w, p2_w, p3_w, p4_w} = 4'b1111;
        f1_w = 1'b1;
      end else begin
        pc_en_w = 1'b1;
        {p1_w, p2_w, p3_w, p4_w} = 4'b1111;
      end
    end
  end

  // Outputs are held low while reset is asserted, independent of the clock.
  always_comb begin
    pc_en    = nRST & pc_en_w;
    pipe1_en = nRST & p1_w;
    pipe2_en = nRST & p2_w;
    pipe3_en = nRST & p3_w;
    pipe4_en = nRST & p4_w;
    flushed1 = nRST & f1_w;
    flushed2 = nRST & f2_w;
  end

  // Next values for the sticky halt flag and the saturating stall counter.
  always_comb begin
    halt_d = halt_q | (state_d == HALTED);
    cnt_d  = cnt_q;
    if ((state_q != HALTED) && !pc_en_w && (cnt_q != 16'hFFFF))
      cnt_d = cnt_q + 16'd1;
  end

  // State, halt and counter registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      halt_q  <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign halt      = halt_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard testbench for pipe_ctrl
module tb_pipe_ctrl;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, dhit, mem_dreq, ex_load, dc_uses_rt, redirect, wb_halt;
  logic [4:0]  ex_wsel, dc_rsel1, dc_rsel2;
  logic        pc_en, pipe1_en, pipe2_en, pipe3_en, pipe4_en, flushed1, flushed2, halt;
  logic [15:0] stall_cnt;

  typedef struct packed {
    logic [6:0]  outs;
    logic        hlt;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] exp_cnt = 16'd0;

  localparam logic [6:0] O_NORM = 7'b1111100;
  localparam logic [6:0] O_LU   = 7'b0011101;
  localparam logic [6:0] O_MISS = 7'b0111110;
  localparam logic [6:0] O_RDR  = 7'b1111111;
  localparam logic [6:0] O_ZERO = 7'b0000000;

  always #5 CLK = ~CLK;

  pipe_ctrl dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dreq(mem_dreq),
    .ex_load(ex_load), .ex_wsel(ex_wsel), .dc_rsel1(dc_rsel1), .dc_rsel2(dc_rsel2),
    .dc_uses_rt(dc_uses_rt), .redirect(redirect), .wb_halt(wb_halt),
    .pc_en(pc_en), .pipe1_en(pipe1_en), .pipe2_en(pipe2_en), .pipe3_en(pipe3_en),
    .pipe4_en(pipe4_en), .flushed1(flushed1), .flushed2(flushed2),
    .halt(halt), .stall_cnt(stall_cnt)
  );

  // Apply one cycle of inputs just after the edge and queue what that cycle must show.
  task automatic vec(input logic rst, input logic ih, input logic dh, input logic mreq,
                     input logic eld, input logic [4:0] ws, input logic [4:0] r1,
                     input logic [4:0] r2, input logic urt, input logic rdr,
                     input logic wh, input logic [6:0] eo, input logic eh);
    exp_t e;
    @(posedge CLK);
    #1;
    nRST = rst; ihit = ih; dhit = dh; mem_dreq = mreq; ex_load = eld;
    ex_wsel = ws; dc_rsel1 = r1; dc_rsel2 = r2; dc_uses_rt = urt;
    redirect = rdr; wb_halt = wh;
    if (!rst) exp_cnt = 16'd0;
    e.outs = eo;
    e.hlt  = eh;
    e.cnt  = exp_cnt;
    sb.push_back(e);
    if (rst && !eh && !eo[6] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
  endtask

  // Monitor: every cycle with a queued expectation is compared mid-cycle.
  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [6:0] act;
      e = sb.pop_front();
      act = {pc_en, pipe1_en, pipe2_en, pipe3_en, pipe4_en, flushed1, flushed2};
      n_vec++;
      if (act !== e.outs || halt !== e.hlt || stall_cnt !== e.cnt) begin
        n_bad++;
        $display("FAIL vec%0d outs/halt/cnt got %b/%b/%h want %b/%b/%h",
                 n_vec, act, halt, stall_cnt, e.outs, e.hlt, e.cnt);
      end
    end
  end

  initial begin
    nRST = 1'b0; ihit = 1'b0; dhit = 1'b0; mem_dreq = 1'b0; ex_load = 1'b0;
    ex_wsel = 5'd0; dc_rsel1 = 5'd0; dc_rsel2 = 5'd0; dc_uses_rt = 1'b0;
    redirect = 1'b0; wb_halt = 1'b0;

    //  rst ih dh mq ld  ws     r1     r2   urt rd wh  expect   halt
    vec(0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_ZERO, 0);
    vec(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_NORM, 0);
    vec(1, 1, 1, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, O_LU,   0);
    vec(1, 1, 1, 0, 0, 5'd0, 5'd5, 5'd0, 0, 0, 0, O_NORM, 0);
    vec(1, 1, 1, 0, 1, 5'd7, 5'd1, 5'd7, 1, 0, 0, O_LU,   0);
    vec(1, 1, 1, 0, 1, 5'd7, 5'd1, 5'd7, 0, 0, 0, O_NORM, 0);
    vec(1, 1, 1, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, O_NORM, 0);
    // memory freeze with redirect held, then released
    vec(1, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, O_ZERO, 0);
    vec(1, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, O_ZERO, 0);
    vec(1, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, O_ZERO, 0);
    vec(1, 1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, O_RDR,  0);
    // redirect beats load-use
    vec(1, 1, 1, 0, 1, 5'd3, 5'd3, 5'd0, 0, 1, 0, O_RDR,  0);
    // redirect during a miss, two wait cycles, squash, then normal
    vec(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, O_RDR,  0);
    vec(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_MISS, 0);
    vec(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_MISS, 0);
    vec(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_MISS, 0);
    vec(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_NORM, 0);
    // REDIR_WAIT ignores load-use, freezes on dstall, then async reset mid-wait
    vec(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, O_RDR,  0);
    vec(1, 0, 1, 0, 1, 5'd4, 5'd4, 5'd0, 0, 0, 0, O_MISS, 0);
    vec(1, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_ZERO, 0);
    vec(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_MISS, 0);
    vec(0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_ZERO, 0);
    vec(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_NORM, 0);
    vec(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_MISS, 0);
    // halt beats dstall and redirect; sticky, counter frozen
    vec(1, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, O_ZERO, 0);
    vec(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_ZERO, 1);
    vec(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, O_ZERO, 1);
    vec(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_ZERO, 0);

    // saturation: long imem miss
    @(posedge CLK);
    #1;
    nRST = 1'b1; ihit = 1'b0;
    repeat (70000) @(posedge CLK);
    exp_cnt = 16'hFFFF;
    vec(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_MISS, 0);
    vec(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_MISS, 0);

    @(negedge CLK);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending got %0d want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
